// File: rtl/escrita_resultado.sv
// Writeback stage after the ULA: writes the 16-bit result into the 8-bit register file.
// MULT results take two writes (low byte to rd, high byte to rd+1). Also keeps a zero flag.
module escrita_resultado #(
  parameter int          REG_AW   = 3,
  parameter int          DATA_W   = 8,
  parameter logic [3:0]  ULA_MULT = 4'd2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            opcode,
  input  logic [REG_AW-1:0]     rd,
  input  logic [2*DATA_W-1:0]   result,
  output logic                  reg_we,
  output logic [REG_AW-1:0]     reg_waddr,
  output logic [DATA_W-1:0]     reg_wdata,
  output logic                  flag_zero,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, WR_LO, WR_HI} state_t;

  state_t                r_state, w_next;
  logic [3:0]            r_op;
  logic [REG_AW-1:0]     r_rd;
  logic [2*DATA_W-1:0]   r_res;
  logic                  r_zero;
  logic                  w_mult, w_xfer, w_zero;

  // ADD, SUB and any unknown opcode are all single-write ops of the low byte.
  assign w_mult    = (r_op == ULA_MULT);
  assign w_xfer    = in_valid & in_ready;
  assign w_zero    = w_mult ? (r_res == '0) : (r_res[DATA_W-1:0] == '0);
  assign flag_zero = r_zero;

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    reg_we    = 1'b0;
    reg_waddr = '0;
    reg_wdata = '0;
    done      = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (w_xfer) w_next = WR_LO;
      end
      WR_LO: begin
        reg_we    = 1'b1;
        reg_waddr = r_rd;
        reg_wdata = r_res[DATA_W-1:0];
        if (w_mult) begin
          w_next = WR_HI;
        end else begin
          in_ready = 1'b1;
          done     = 1'b1;
          w_next   = w_xfer ? WR_LO : IDLE;
        end
      end
      WR_HI: begin
        reg_we    = 1'b1;
        reg_waddr = r_rd + REG_AW'(1);
        reg_wdata = r_res[2*DATA_W-1:DATA_W];
        in_ready  = 1'b1;
        done      = 1'b1;
        w_next    = w_xfer ? WR_LO : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_op    <= '0;
      r_rd    <= '0;
      r_res   <= '0;
      r_zero  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_xfer) begin
        r_op  <= opcode;
        r_rd  <= rd;
        r_res <= result;
      end
      // The flag loads from the operation finishing this cycle, before any new capture lands.
      if (done) r_zero <= w_zero;
    end
  end

endmodule

// File: tb/tb_escrita_resultado.sv
// Bench for escrita_resultado: table of single ops plus back-to-back and reset corner cases,
// with a write scoreboard filled on each accepted transfer and drained by a monitor.
module tb_escrita_resultado;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MULT = 4'd2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  opcode = '0;
  logic [2:0]  rd = '0;
  logic [15:0] result = '0;
  logic        reg_we;
  logic [2:0]  reg_waddr;
  logic [7:0]  reg_wdata;
  logic        flag_zero;
  logic        done;

  escrita_resultado #(.REG_AW(3), .DATA_W(8), .ULA_MULT(OP_MULT)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .result(result), .reg_we(reg_we),
    .reg_waddr(reg_waddr), .reg_wdata(reg_wdata), .flag_zero(flag_zero), .done(done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  op;
    logic [2:0]  rd;
    logic [15:0] res;
    logic        zf;
  } vec_t;

  typedef struct {
    logic [2:0] a;
    logic [7:0] d;
    logic       dn;
    logic       rdy;
  } exp_t;

  exp_t sbq[$];
  int   wr_log[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  logic mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every visible write must match the head of the scoreboard.
  always @(negedge clock) begin
    exp_t e;
    cyc++;
    if (mon_en && reset && reg_we) begin
      if (sbq.size() == 0) begin
        chk("unexpected_write", 32'(reg_waddr), 32'hFFFF);
      end else begin
        e = sbq.pop_front();
        chk("waddr", 32'(reg_waddr), 32'(e.a));
        chk("wdata", 32'(reg_wdata), 32'(e.d));
        chk("done",  32'(done),      32'(e.dn));
        chk("in_ready_during_write", 32'(in_ready), 32'(e.rdy));
        wr_log.push_back(cyc);
      end
    end
  end

  // Called at a negedge; returns at the negedge right after the transfer edge.
  task automatic send(input logic [3:0] op, input logic [2:0] r, input logic [15:0] res);
    int t = 0;
    exp_t e;
    opcode = op; rd = r; result = res; in_valid = 1'b1;
    while (!in_ready && t < 20) begin
      @(negedge clock);
      t++;
    end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
    if (op == OP_MULT) begin
      e.a = r;        e.d = res[7:0];  e.dn = 1'b0; e.rdy = 1'b0; sbq.push_back(e);
      e.a = r + 3'd1; e.d = res[15:8]; e.dn = 1'b1; e.rdy = 1'b1; sbq.push_back(e);
    end else begin
      e.a = r;        e.d = res[7:0];  e.dn = 1'b1; e.rdy = 1'b1; sbq.push_back(e);
    end
    @(negedge clock);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{OP_ADD,  3'd3, 16'h00A5, 1'b0};
    vecs[1] = '{OP_SUB,  3'd1, 16'h0000, 1'b1};
    vecs[2] = '{OP_MULT, 3'd7, 16'h3C2A, 1'b0};
    vecs[3] = '{OP_SUB,  3'd5, 16'hFF00, 1'b1};
    vecs[4] = '{OP_MULT, 3'd0, 16'h0100, 1'b0};
    vecs[5] = '{OP_MULT, 3'd4, 16'h0000, 1'b1};
    vecs[6] = '{4'hF,    3'd6, 16'h1200, 1'b1};
    vecs[7] = '{OP_ADD,  3'd2, 16'h0001, 1'b0};

    // Reset held with in_valid asserted.
    in_valid = 1'b1; opcode = OP_ADD; rd = 3'd5; result = 16'h0000;
    repeat (3) @(negedge clock);
    chk("rst_reg_we",    32'(reg_we),    32'd0);
    chk("rst_done",      32'(done),      32'd0);
    chk("rst_flag_zero", 32'(flag_zero), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_waddr",     32'(reg_waddr), 32'd0);
    chk("rst_wdata",     32'(reg_wdata), 32'd0);
    in_valid = 1'b0;
    reset = 1'b1;
    mon_en = 1'b1;
    chk("ready_after_release", 32'(in_ready), 32'd1);

    foreach (vecs[i]) begin
      int t = 0;
      send(vecs[i].op, vecs[i].rd, vecs[i].res);
      in_valid = 1'b0;
      while (!done && t < 10) begin
        @(negedge clock);
        t++;
      end
      chk($sformatf("vec%0d_done_seen", i), 32'(done), 32'd1);
      @(negedge clock);
      chk($sformatf("vec%0d_flag_zero", i), 32'(flag_zero), 32'(vecs[i].zf));
      chk($sformatf("vec%0d_idle_we", i),   32'(reg_we),    32'd0);
    end

    // Back-to-back with in_valid held high: five writes on consecutive cycles.
    wr_log.delete();
    send(OP_ADD,  3'd1, 16'h0011);
    send(OP_ADD,  3'd2, 16'h0022);
    send(OP_MULT, 3'd4, 16'hBBAA);
    send(OP_ADD,  3'd6, 16'h0066);
    in_valid = 1'b0;
    repeat (3) @(negedge clock);
    chk("b2b_write_count", 32'(wr_log.size()), 32'd5);
    if (wr_log.size() == 5) chk("b2b_no_gaps", 32'(wr_log[4] - wr_log[0]), 32'd4);
    chk("b2b_sb_empty", 32'(sbq.size()), 32'd0);

    // Reset during the low-byte write of a MULT.
    mon_en = 1'b0;
    opcode = OP_MULT; rd = 3'd2; result = 16'h5577; in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    chk("mid_lo_we",    32'(reg_we),    32'd1);
    chk("mid_lo_waddr", 32'(reg_waddr), 32'd2);
    chk("mid_lo_ready", 32'(in_ready),  32'd0);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_we",    32'(reg_we),    32'd0);
    chk("mid_rst_waddr", 32'(reg_waddr), 32'd0);
    chk("mid_rst_wdata", 32'(reg_wdata), 32'd0);
    chk("mid_rst_done",  32'(done),      32'd0);
    chk("mid_rst_ready", 32'(in_ready),  32'd1);
    chk("mid_rst_flag",  32'(flag_zero), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("mid_no_hi_write", 32'(reg_we), 32'd0);
    chk("mid_idle_ready",  32'(in_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/escrita_resultado.md
Name: escrita_resultado

Overview:
Writeback stage directly downstream of the ULA in the processinho datapath. It accepts the ULA's 16-bit result together with the opcode and destination register index, then writes the result into the 8-bit register file. ADD and SUB results take one write cycle. MULT results take two write cycles: low byte to rd, high byte to rd+1. It also maintains a registered zero flag for later branch logic.

Parameters:
REG_AW, 3, register-file address width (2**REG_AW registers)
DATA_W, 8, register-file data width; result width is 2*DATA_W

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
in_valid  input  1  ULA result, opcode and rd are valid this cycle
in_ready  output  1  stage can accept a new result this cycle
opcode  input  4  operation that produced result (`ULA_ADD / `ULA_SUB / `ULA_MULT from constants.vh)
rd  input  REG_AW  destination register index
result  input  2*DATA_W  ULA result
reg_we  output  1  register-file write enable
reg_waddr  output  REG_AW  register-file write address
reg_wdata  output  DATA_W  register-file write data
flag_zero  output  1  1 when the last completed writeback value was zero
done  output  1  one-cycle pulse on the final write of each operation

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE, reg_we=0, reg_waddr=0, reg_wdata=0, flag_zero=0, done=0, and all internal capture registers are 0. in_ready is 1 after reset.
- Handshake: transfer occurs when in_valid && in_ready at a rising edge. On transfer, opcode, rd and result are captured into internal registers. Inputs are ignored when no transfer occurs.
- FSM states: IDLE, WR_LO, WR_HI.
  - IDLE: in_ready=1, reg_we=0. On transfer, go to WR_LO.
  - WR_LO: reg_we=1, reg_waddr=rd_q, reg_wdata=result_q[DATA_W-1:0].
    - If op_q==`ULA_MULT: in_ready=0, next state WR_HI.
    - Otherwise this is the final write: done=1, in_ready=1. On a simultaneous transfer, capture the new operation and stay in WR_LO. Without a transfer, go to IDLE.
  - WR_HI: reg_we=1, reg_waddr=rd_q+1 (modulo 2**REG_AW, so 7 wraps to 0), reg_wdata=result_q[2*DATA_W-1:DATA_W], done=1, in_ready=1. On a simultaneous transfer, capture and go to WR_LO; otherwise go to IDLE.
- Output registration: reg_we, reg_waddr, reg_wdata and done are registered (driven from state/capture registers). in_ready is combinational from state and op_q only, with no path from in_valid.
- Latency: first write occurs the cycle after transfer. ADD/SUB take 1 write cycle; MULT takes 2 consecutive write cycles.
- Throughput: back-to-back ADD/SUB writes 1 op/cycle; MULT writes 1 op per 2 cycles. There are no bubbles when in_valid is held high.
- Unknown opcode (not ADD/SUB/MULT): accepted and treated as a single-write op of the low byte. This matches the ULA, whose result is held for undefined opcodes.
- flag_zero: updated only in the cycle done is asserted.
  - ADD/SUB/other: 1 iff result_q[DATA_W-1:0]==0.
  - MULT: 1 iff the full result_q==0.
  - Holds its value otherwise.
- Reset mid-operation (e.g. in WR_LO of a MULT): abort immediately. The high byte is never written and reg_we drops asynchronously.
- No write suppression for register 0; the register file owns that policy.

Test Plan:
- Reset: hold reset=0 with in_valid=1 -> reg_we=0, done=0, flag_zero=0, in_ready=1. After release, a transfer is accepted on the first edge.
- ADD single: opcode=`ULA_ADD, rd=3, result=16'h00A5 -> next cycle reg_we=1, waddr=3, wdata=8'hA5, done=1, flag_zero=0. The following cycle reg_we=0.
- MULT with wrap: opcode=`ULA_MULT, rd=7, result=16'h3C2A -> cycle+1 waddr=7, wdata=8'h2A, in_ready=0, done=0. Cycle+2 waddr=0, wdata=8'h3C, done=1.
- Zero flag: SUB result=16'h0000 -> flag_zero=1. Then MULT result=16'h0100 -> flag_zero=0, even though the low byte is 0.
- Back-to-back: in_valid held high with ADD,ADD,MULT,ADD (rd=1,2,4,6) -> writes on consecutive cycles to 1,2,4,5,6 with no idle cycles. in_ready=0 only during the MULT low-byte cycle.
- Reset mid-MULT: assert reset during WR_LO of MULT rd=2 -> no write to reg 3, state=IDLE, outputs at their reset values.
